// File: rtl/fft_out_serializer_if.sv
// Handshake bundle between an FFT stage and its output serializer:
// a parallel 32-word frame on the load side and a serial word stream out.
interface fft_out_serializer_if #(
  parameter int bits = 16
);
  logic [2*bits-1:0] in0,  in1,  in2,  in3,  in4,  in5,  in6,  in7;
  logic [2*bits-1:0] in8,  in9,  in10, in11, in12, in13, in14, in15;
  logic [2*bits-1:0] in16, in17, in18, in19, in20, in21, in22, in23;
  logic [2*bits-1:0] in24, in25, in26, in27, in28, in29, in30, in31;
  logic              load_valid;
  logic              load_ready;
  logic              bitrev;
  logic [2*bits-1:0] out_data;
  logic [4:0]        out_index;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic [7:0]        frame_count;

  modport master (
    output in0,  in1,  in2,  in3,  in4,  in5,  in6,  in7,
           in8,  in9,  in10, in11, in12, in13, in14, in15,
           in16, in17, in18, in19, in20, in21, in22, in23,
           in24, in25, in26, in27, in28, in29, in30, in31,
           load_valid, bitrev, out_ready,
    input  load_ready, out_data, out_index, out_valid, out_last, frame_count
  );

  modport slave (
    input  in0,  in1,  in2,  in3,  in4,  in5,  in6,  in7,
           in8,  in9,  in10, in11, in12, in13, in14, in15,
           in16, in17, in18, in19, in20, in21, in22, in23,
           in24, in25, in26, in27, in28, in29, in30, in31,
           load_valid, bitrev, out_ready,
    output load_ready, out_data, out_index, out_valid, out_last, frame_count
  );
endinterface

// File: rtl/fft_out_serializer.sv
// Captures a 32-point FFT frame in parallel and streams it out one word per
// cycle, in natural or bit-reversed index order, with zero-bubble reload.
module fft_out_serializer #(
  parameter int fix_bit = 7,
  parameter int bits    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  fft_out_serializer_if.slave   bus
);
  localparam int W = 2 * bits;

  // The binary point is only carried through; it must still lie inside a half-word.
  if (fix_bit < 0 || fix_bit >= bits) begin : g_bad_fix_bit
    $error("fix_bit must be in [0, bits-1]");
  end

  typedef enum logic {IDLE, SEND} state_t;

  state_t         state_q;
  logic [4:0]     cnt_q;
  logic [W-1:0]   buf_q [32];
  logic           bitrev_q;
  logic [7:0]     frame_count_q;
  logic [W-1:0]   out_data_q;
  logic [4:0]     out_index_q;
  logic           out_valid_q;
  logic           out_last_q;

  logic [W-1:0]   in_frame [32];
  logic [4:0]     cnt_d;
  logic [4:0]     idx_d;
  logic           load;
  logic           xfer;
  logic           frame_end;

  assign in_frame[0]  = bus.in0;  assign in_frame[1]  = bus.in1;
  assign in_frame[2]  = bus.in2;  assign in_frame[3]  = bus.in3;
  assign in_frame[4]  = bus.in4;  assign in_frame[5]  = bus.in5;
  assign in_frame[6]  = bus.in6;  assign in_frame[7]  = bus.in7;
  assign in_frame[8]  = bus.in8;  assign in_frame[9]  = bus.in9;
  assign in_frame[10] = bus.in10; assign in_frame[11] = bus.in11;
  assign in_frame[12] = bus.in12; assign in_frame[13] = bus.in13;
  assign in_frame[14] = bus.in14; assign in_frame[15] = bus.in15;
  assign in_frame[16] = bus.in16; assign in_frame[17] = bus.in17;
  assign in_frame[18] = bus.in18; assign in_frame[19] = bus.in19;
  assign in_frame[20] = bus.in20; assign in_frame[21] = bus.in21;
  assign in_frame[22] = bus.in22; assign in_frame[23] = bus.in23;
  assign in_frame[24] = bus.in24; assign in_frame[25] = bus.in25;
  assign in_frame[26] = bus.in26; assign in_frame[27] = bus.in27;
  assign in_frame[28] = bus.in28; assign in_frame[29] = bus.in29;
  assign in_frame[30] = bus.in30; assign in_frame[31] = bus.in31;

  function automatic logic [4:0] rev5(input logic [4:0] c);
    return {c[0], c[1], c[2], c[3], c[4]};
  endfunction

  // Accepting on the last word's transfer edge is what makes back-to-back frames gapless.
  assign bus.load_ready = reset &&
                          ((state_q == IDLE) || (cnt_q == 5'd31 && bus.out_ready));
  assign load      = bus.load_valid && bus.load_ready;
  assign xfer      = (state_q == SEND) && bus.out_ready;
  assign frame_end = xfer && (cnt_q == 5'd31);
  assign cnt_d     = cnt_q + 5'd1;
  assign idx_d     = bitrev_q ? rev5(cnt_d) : cnt_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      bitrev_q      <= 1'b0;
      frame_count_q <= '0;
      out_data_q    <= '0;
      out_index_q   <= '0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      // NOTE: the frame buffer is cleared on reset so a stale frame can never leak out after an abort.
      for (int i = 0; i < 32; i++) buf_q[i] <= '0;
    end else begin
      if (frame_end) frame_count_q <= frame_count_q + 8'd1;

      if (load) begin
        // Index 0 is its own bit reversal, so the first word is the same in both orders.
        state_q     <= SEND;
        buf_q       <= in_frame;
        bitrev_q    <= bus.bitrev;
        cnt_q       <= '0;
        out_data_q  <= in_frame[0];
        out_index_q <= '0;
        out_valid_q <= 1'b1;
        out_last_q  <= 1'b0;
      end else if (frame_end) begin
        state_q     <= IDLE;
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end else if (xfer) begin
        cnt_q       <= cnt_d;
        out_index_q <= idx_d;
        out_data_q  <= buf_q[idx_d];
        out_last_q  <= (cnt_d == 5'd31);
      end
    end
  end

  assign bus.out_data    = out_data_q;
  assign bus.out_index   = out_index_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_last    = out_last_q;
  assign bus.frame_count = frame_count_q;
endmodule

// File: doc/fft_out_serializer.md
FFT_OUT_SERIALIZER -- requirements
Module: fft_out_serializer

Interface
REQ-001 SHALL have parameter fix_bit, default 7, fractional bits of each fixed-point half-word (carried through only, no arithmetic).
REQ-002 SHALL have parameter bits, default 16, width of each real/imag half; a word is 2*bits wide {real, imag}.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports in0..in31  input  2*bits each  parallel 32-point frame from the FFT stage output registers.
REQ-006 SHALL have port load_valid  input  1  frame on in0..in31 is valid.
REQ-007 SHALL have port load_ready  output  1  block accepts a frame this cycle.
REQ-008 SHALL have port bitrev  input  1  sampled with the frame; 1 = emit in bit-reversed index order.
REQ-009 SHALL have port out_data  output  2*bits  current serial word.
REQ-010 SHALL have port out_index  output  5  frame index of out_data.
REQ-011 SHALL have port out_valid  output  1  out_data valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts the word.
REQ-013 SHALL have port out_last  output  1  current word is the 32nd of the frame.
REQ-014 SHALL have port frame_count  output  8  number of completed frames, modulo 256.

Function
REQ-015 SHALL implement FSM states IDLE and SEND, plus a 5-bit word counter cnt, a 32-word frame buffer, and a registered bitrev flag.
REQ-016 load_ready SHALL be 1 in IDLE, and in SEND only when cnt==31 and out_ready==1 (combinational path from out_ready); 0 otherwise.
REQ-017 A load SHALL occur on a clock edge where load_valid && load_ready: capture in0..in31 into the buffer, capture bitrev, set cnt=0, next state SEND.
REQ-018 Latency: first word (index 0 position) SHALL be on out_data with out_valid=1 in the cycle immediately after the load edge.
REQ-019 In SEND, out_valid SHALL be 1, out_index = cnt (bitrev=0) or 5-bit reversal of cnt (bitrev=1), out_data = buffer[out_index], out_last = (cnt==31).
REQ-020 A transfer SHALL occur on an edge where out_valid && out_ready; cnt increments by 1 per transfer.
REQ-021 While out_ready=0, out_data, out_index, out_last SHALL hold stable; cnt and buffer unchanged.
REQ-022 On the transfer with cnt==31: frame_count increments (wrap 255 -> 0); if a load occurs on the same edge, state stays SEND with cnt=0 and the new frame (zero-bubble back-to-back); otherwise state -> IDLE.
REQ-023 load_valid while load_ready=0 SHALL be ignored; buffer and bitrev SHALL not change during SEND except per REQ-022.
REQ-024 In IDLE, out_valid=0, out_last=0; out_data/out_index hold their last values.
REQ-025 Words SHALL pass bit-exact; no rounding, saturation or sign handling.
REQ-026 Sustained throughput SHALL be one word per cycle with out_ready held 1, i.e. one frame per 32 cycles.

Reset
REQ-027 While reset=0: state IDLE, cnt=0, buffer=0, bitrev flag=0, frame_count=0, out_data=0, out_index=0, out_valid=0, out_last=0, load_ready=0.
REQ-028 After reset rises, load_ready SHALL be 1 from the first cycle; reset asserted mid-frame SHALL abort the frame immediately (asynchronously) with no frame_count increment.

Verification
REQ-029 in_k = {k, 0x100+k}, bitrev=0, out_ready=1, one load -> 32 consecutive words, out_index 0..31, out_data {k,0x100+k}, out_last only on index 31, frame_count=1, then IDLE.
REQ-030 Same frame, bitrev=1 -> out_index sequence 0,16,8,24,4,20,...,31; out_data matches index; out_last on 32nd word (index 31).
REQ-031 out_ready toggled 1,0,0,1,... during a frame -> no words lost or duplicated, outputs stable on stall cycles, frame still ends after exactly 32 transfers.
REQ-032 load_valid held 1 with three distinct frames, out_ready=1 -> 96 words with no gap, load_ready pulses only at cnt==31, frame_count=3; load_valid during mid-frame changes nothing.
REQ-033 reset driven low at word 10 of a frame -> out_valid=0 immediately, frame_count=0, all outputs 0; after release a new load streams normally from index 0.
REQ-034 Run 256 frames -> frame_count wraps to 0.
